// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes seen by the ALU and the multi-cycle
// multiply/divide sequencer, plus the sequencer state encoding.
package alu_pkg;

    localparam logic [3:0] OP_SUMA    = 4'b0000;
    localparam logic [3:0] OP_RESTA   = 4'b0001;
    localparam logic [3:0] OP_MUL     = 4'b0010;
    localparam logic [3:0] OP_DIV     = 4'b0011;
    localparam logic [3:0] OP_AND     = 4'b0100;
    localparam logic [3:0] OP_OR      = 4'b0101;
    localparam logic [3:0] OP_XOR     = 4'b0110;
    localparam logic [3:0] OP_SLL     = 4'b0111;
    localparam logic [3:0] OP_SLT     = 4'b1000;
    localparam logic [3:0] OP_INVALID = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } seq_state_t;

    function automatic logic is_mul_div(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mul_div_step.sv
// One iteration of the unsigned datapath: shift-add multiply or restoring
// divide on a 2*WIDTH accumulator {hi, lo}.
module mul_div_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     opnd,
    output logic [2*WIDTH-1:0]   acc_nxt
);

    logic [WIDTH:0]       sum_s;
    logic [WIDTH:0]       rem_sh_s;
    logic [WIDTH:0]       diff_s;
    logic [2*WIDTH-1:0]   mul_res_s;
    logic [2*WIDTH-1:0]   div_res_s;

    // Multiply keeps the add carry as the new top bit after the right shift;
    // divide keeps the shifted remainder when the trial subtraction goes negative.
    always_comb begin
        sum_s     = {1'b0, acc[2*WIDTH-1:WIDTH]};
        rem_sh_s  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff_s    = rem_sh_s - {1'b0, opnd};
        mul_res_s = acc;
        div_res_s = acc;
        acc_nxt   = acc;

        if (acc[0]) begin
            sum_s = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        end else begin
            sum_s = {1'b0, acc[2*WIDTH-1:WIDTH]};
        end
        mul_res_s = {sum_s, acc[WIDTH-1:1]};

        if (diff_s[WIDTH]) begin
            div_res_s = {rem_sh_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            div_res_s = {diff_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end

        if (is_div) begin
            acc_nxt = div_res_s;
        end else begin
            acc_nxt = mul_res_s;
        end
    end

endmodule

// File: rtl/mul_div_sequencer.sv
// Multi-cycle multiply/divide sequencer beside the ALU: magnitudes are iterated
// for WIDTH cycles, signs are applied in FIX, and the result is exposed in DONE.
module mul_div_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       operacion,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero,
    output logic             invalid_op
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    seq_state_t           state_r, state_nxt_s;
    logic [CNT_W-1:0]     cnt_r, cnt_nxt_s;
    logic [2*WIDTH-1:0]   acc_r, acc_nxt_s, step_acc_s, prod_s;
    logic [WIDTH-1:0]     opnd_r, opnd_nxt_s;
    logic                 is_div_r, is_div_nxt_s;
    logic                 neg_res_r, neg_res_nxt_s;
    logic                 neg_rem_r, neg_rem_nxt_s;
    logic [WIDTH-1:0]     mag_a_s, mag_b_s, quo_s, rem_s;
    logic [WIDTH-1:0]     hi_r, hi_nxt_s, lo_r, lo_nxt_s;
    logic                 busy_r, done_r, dbz_r, dbz_nxt_s, inv_r, inv_nxt_s;

    mul_div_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div_r),
        .acc     (acc_r),
        .opnd    (opnd_r),
        .acc_nxt (step_acc_s)
    );

    // Operand magnitudes and sign-corrected results of the finished iteration.
    always_comb begin
        mag_a_s = op_a;
        mag_b_s = op_b;
        prod_s  = acc_r;
        quo_s   = acc_r[WIDTH-1:0];
        rem_s   = acc_r[2*WIDTH-1:WIDTH];
        if (signed_op && op_a[WIDTH-1]) mag_a_s = -op_a; else mag_a_s = op_a;
        if (signed_op && op_b[WIDTH-1]) mag_b_s = -op_b; else mag_b_s = op_b;
        if (neg_res_r) begin
            prod_s = -acc_r;
            quo_s  = -acc_r[WIDTH-1:0];
        end else begin
            prod_s = acc_r;
            quo_s  = acc_r[WIDTH-1:0];
        end
        if (neg_rem_r) rem_s = -acc_r[2*WIDTH-1:WIDTH]; else rem_s = acc_r[2*WIDTH-1:WIDTH];
    end

    // Next-state and next-register logic of the sequencer.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        acc_nxt_s     = acc_r;
        opnd_nxt_s    = opnd_r;
        is_div_nxt_s  = is_div_r;
        neg_res_nxt_s = neg_res_r;
        neg_rem_nxt_s = neg_rem_r;
        hi_nxt_s      = hi_r;
        lo_nxt_s      = lo_r;
        dbz_nxt_s     = dbz_r;
        inv_nxt_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (operacion == OP_DIV && op_b == {WIDTH{1'b0}}) begin
                        hi_nxt_s    = op_a;
                        lo_nxt_s    = {WIDTH{1'b1}};
                        dbz_nxt_s   = 1'b1;
                        state_nxt_s = ST_DONE;
                    end else if (is_mul_div(operacion)) begin
                        is_div_nxt_s  = (operacion == OP_DIV);
                        neg_res_nxt_s = signed_op && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        neg_rem_nxt_s = signed_op && op_a[WIDTH-1];
                        cnt_nxt_s     = {CNT_W{1'b0}};
                        state_nxt_s   = ST_RUN;
                        if (operacion == OP_DIV) begin
                            acc_nxt_s  = {{WIDTH{1'b0}}, mag_a_s};
                            opnd_nxt_s = mag_b_s;
                        end else begin
                            acc_nxt_s  = {{WIDTH{1'b0}}, mag_b_s};
                            opnd_nxt_s = mag_a_s;
                        end
                    end else begin
                        inv_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    acc_nxt_s = step_acc_s;
                    cnt_nxt_s = cnt_r + 1'b1;
                    if (cnt_r == CNT_LAST) state_nxt_s = ST_FIX; else state_nxt_s = ST_RUN;
                end
            end
            ST_FIX: begin
                if (abort) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    // Most-negative / -1 wraps naturally through the magnitude path.
                    if (is_div_r) begin
                        hi_nxt_s = rem_s;
                        lo_nxt_s = quo_s;
                    end else begin
                        hi_nxt_s = prod_s[2*WIDTH-1:WIDTH];
                        lo_nxt_s = prod_s[WIDTH-1:0];
                    end
                    dbz_nxt_s   = 1'b0;
                    state_nxt_s = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            acc_r     <= {(2*WIDTH){1'b0}};
            opnd_r    <= {WIDTH{1'b0}};
            is_div_r  <= 1'b0;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            dbz_r     <= 1'b0;
            inv_r     <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            acc_r     <= acc_nxt_s;
            opnd_r    <= opnd_nxt_s;
            is_div_r  <= is_div_nxt_s;
            neg_res_r <= neg_res_nxt_s;
            neg_rem_r <= neg_rem_nxt_s;
            hi_r      <= hi_nxt_s;
            lo_r      <= lo_nxt_s;
            busy_r    <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_FIX);
            done_r    <= (state_nxt_s == ST_DONE);
            dbz_r     <= dbz_nxt_s;
            inv_r     <= inv_nxt_s;
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign hi          = hi_r;
    assign lo          = lo_r;
    assign div_by_zero = dbz_r;
    assign invalid_op  = inv_r;

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Directed self-checking bench for mul_div_sequencer (WIDTH=32).
module tb_mul_div_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  operacion;
    logic        signed_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        abort;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;
    logic        invalid_op;

    int total = 0;
    int bad   = 0;
    int cyc;
    int busy_cnt;
    int done_cnt;

    mul_div_sequencer #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .operacion   (operacion),
        .signed_op   (signed_op),
        .op_a        (op_a),
        .op_b        (op_b),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero),
        .invalid_op  (invalid_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one op and wait (bounded) for done; cyc counts cycles since acceptance.
    task automatic run_op(input logic [3:0] op, input logic sg, input logic [31:0] a, input logic [31:0] b);
        operacion = op; signed_op = sg; op_a = a; op_b = b; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        busy_cnt = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (busy === 1'b1) busy_cnt++;
            tick();
            cyc++;
        end
    endtask

    task automatic count_dones(input int n);
        done_cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (done === 1'b1) done_cnt++;
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; operacion = 4'b0000; signed_op = 1'b0;
        op_a = 32'd0; op_b = 32'd0; abort = 1'b0;
        tick(); tick();
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_dbz",  {63'd0, div_by_zero}, 64'd0);
        check("rst_inv",  {63'd0, invalid_op}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Unsigned 7 x 6
        run_op(4'b0010, 1'b0, 32'd7, 32'd6);
        check("mul7x6_lat",  64'(cyc), 64'd34);
        check("mul7x6_busy", 64'(busy_cnt), 64'd33);
        check("mul7x6_busy_at_done", {63'd0, busy}, 64'd0);
        check("mul7x6_res",  {hi, lo}, {32'd0, 32'd42});
        tick();
        check("mul7x6_done_pulse", {63'd0, done}, 64'd0);

        run_op(4'b0010, 1'b1, 32'hFFFFFFFD, 32'd5);
        check("smul_m3x5", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFF1});
        tick();
        run_op(4'b0010, 1'b0, 32'hFFFFFFFF, 32'd2);
        check("umul_max_x2", {hi, lo}, {32'd1, 32'hFFFFFFFE});
        tick();
        run_op(4'b0011, 1'b0, 32'd100, 32'd7);
        check("udiv_100_7_lat", 64'(cyc), 64'd34);
        check("udiv_100_7", {hi, lo}, {32'd2, 32'd14});
        tick();
        run_op(4'b0011, 1'b1, 32'hFFFFFFF9, 32'd2);
        check("sdiv_m7_2", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFD});
        tick();
        run_op(4'b0011, 1'b1, 32'h80000000, 32'hFFFFFFFF);
        check("sdiv_ovf", {hi, lo}, {32'd0, 32'h80000000});
        check("sdiv_ovf_dbz", {63'd0, div_by_zero}, 64'd0);
        tick();

        // Divide by zero finishes in one cycle and the flag is sticky
        run_op(4'b0011, 1'b0, 32'd55, 32'd0);
        check("dbz_lat", 64'(cyc), 64'd1);
        check("dbz_res", {hi, lo}, {32'd55, 32'hFFFFFFFF});
        check("dbz_flag", {63'd0, div_by_zero}, 64'd1);
        check("dbz_busy", {63'd0, busy}, 64'd0);
        tick();
        check("dbz_sticky", {63'd0, div_by_zero}, 64'd1);
        run_op(4'b0010, 1'b0, 32'd2, 32'd2);
        check("mul2x2_res", {hi, lo}, {32'd0, 32'd4});
        check("mul2x2_dbz_clr", {63'd0, div_by_zero}, 64'd0);
        tick();

        // start during RUN is ignored
        operacion = 4'b0010; signed_op = 1'b0; op_a = 32'd3; op_b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 100) begin
            if (cyc == 10) begin start = 1'b1; op_a = 32'd5; op_b = 32'd5; end
            else if (cyc == 11) start = 1'b0;
            tick();
            cyc++;
        end
        check("restart_lat", 64'(cyc), 64'd34);
        check("restart_res", {hi, lo}, {32'd0, 32'd9});
        // start in the done cycle is ignored too
        op_a = 32'd4; op_b = 32'd4; start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_done_busy", {63'd0, busy}, 64'd0);
        count_dones(40);
        check("restart_no_second_done", 64'(done_cnt), 64'd0);
        check("restart_hold", {hi, lo}, {32'd0, 32'd9});

        // Unsupported code
        operacion = 4'b0100; op_a = 32'd1; op_b = 32'd1; start = 1'b1;
        tick();
        start = 1'b0;
        check("inv_pulse", {63'd0, invalid_op}, 64'd1);
        check("inv_busy", {63'd0, busy}, 64'd0);
        tick();
        check("inv_pulse_end", {63'd0, invalid_op}, 64'd0);
        check("inv_hold", {hi, lo}, {32'd0, 32'd9});

        // Abort in the middle of a divide
        operacion = 4'b0011; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (14) tick();
        check("abort_busy_before", {63'd0, busy}, 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy_after", {63'd0, busy}, 64'd0);
        count_dones(40);
        check("abort_no_done", 64'(done_cnt), 64'd0);
        check("abort_hold", {hi, lo}, {32'd0, 32'd9});

        // Reset in the middle of a multiply
        operacion = 4'b0010; op_a = 32'd7; op_b = 32'd6; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_hilo", {hi, lo}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run_op(4'b0010, 1'b0, 32'd7, 32'd6);
        check("post_rst_lat", 64'(cyc), 64'd34);
        check("post_rst_res", {hi, lo}, {32'd0, 32'd42});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
